axi2wbm: RTL and testbench

AXI4 slave to pipelined-Wishbone master bridge, the opposite direction of the team's Wishbone-to-AXI translator in front of the MIG SDRAM. It lets AXI initiators (DMA, video engines) reach the existing Wishbone peripheral bus. Each AXI burst becomes a sequence of single-beat Wishbone transactions with one outstanding request. Reads and writes share the single Wishbone master port under round-robin arbitration.

---
 rtl/axi2wbm_if.sv | 83 ++++++++
 rtl/axi2wbm.sv | 240 ++++++++++++++++++++++++
 tb/tb_axi2wbm.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi2wbm_if.sv
// axi2wbm_if: bundles the AXI4 slave channels and the pipelined Wishbone
// master port of the axi2wbm bridge.
//   slave  : the bridge's view. It is the AXI slave and drives the Wishbone
//            request signals.
//   master : the environment's view. It is the AXI initiator and also plays
//            the Wishbone peripheral.
// Signal names keep their i_/o_ prefixes as seen from the bridge.
interface axi2wbm_if #(
    parameter int C_AXI_ID_WIDTH   = 1,
    parameter int C_AXI_ADDR_WIDTH = 28,
    parameter int C_AXI_DATA_WIDTH = 32
);
    localparam int AW = C_AXI_ADDR_WIDTH - 2;
    localparam int SW = C_AXI_DATA_WIDTH / 8;

    logic [C_AXI_ID_WIDTH-1:0]   i_axi_awid;
    logic [C_AXI_ADDR_WIDTH-1:0] i_axi_awaddr;
    logic [7:0]                  i_axi_awlen;
    logic [1:0]                  i_axi_awburst;
    logic                        i_axi_awvalid;
    logic                        o_axi_awready;
    logic [C_AXI_DATA_WIDTH-1:0] i_axi_wdata;
    logic [SW-1:0]               i_axi_wstrb;
    logic                        i_axi_wlast;
    logic                        i_axi_wvalid;
    logic                        o_axi_wready;
    logic [C_AXI_ID_WIDTH-1:0]   o_axi_bid;
    logic [1:0]                  o_axi_bresp;
    logic                        o_axi_bvalid;
    logic                        i_axi_bready;
    logic [C_AXI_ID_WIDTH-1:0]   i_axi_arid;
    logic [C_AXI_ADDR_WIDTH-1:0] i_axi_araddr;
    logic [7:0]                  i_axi_arlen;
    logic [1:0]                  i_axi_arburst;
    logic                        i_axi_arvalid;
    logic                        o_axi_arready;
    logic [C_AXI_ID_WIDTH-1:0]   o_axi_rid;
    logic [C_AXI_DATA_WIDTH-1:0] o_axi_rdata;
    logic [1:0]                  o_axi_rresp;
    logic                        o_axi_rlast;
    logic                        o_axi_rvalid;
    logic                        i_axi_rready;
    logic                        o_wb_cyc;
    logic                        o_wb_stb;
    logic                        o_wb_we;
    logic [AW-1:0]               o_wb_addr;
    logic [C_AXI_DATA_WIDTH-1:0] o_wb_data;
    logic [SW-1:0]               o_wb_sel;
    logic                        i_wb_stall;
    logic                        i_wb_ack;
    logic                        i_wb_err;
    logic [C_AXI_DATA_WIDTH-1:0] i_wb_data;

    modport slave (
        input  i_axi_awid, i_axi_awaddr, i_axi_awlen, i_axi_awburst, i_axi_awvalid,
        output o_axi_awready,
        input  i_axi_wdata, i_axi_wstrb, i_axi_wlast, i_axi_wvalid,
        output o_axi_wready,
        output o_axi_bid, o_axi_bresp, o_axi_bvalid,
        input  i_axi_bready,
        input  i_axi_arid, i_axi_araddr, i_axi_arlen, i_axi_arburst, i_axi_arvalid,
        output o_axi_arready,
        output o_axi_rid, o_axi_rdata, o_axi_rresp, o_axi_rlast, o_axi_rvalid,
        input  i_axi_rready,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
        input  i_wb_stall, i_wb_ack, i_wb_err, i_wb_data
    );

    modport master (
        output i_axi_awid, i_axi_awaddr, i_axi_awlen, i_axi_awburst, i_axi_awvalid,
        input  o_axi_awready,
        output i_axi_wdata, i_axi_wstrb, i_axi_wlast, i_axi_wvalid,
        input  o_axi_wready,
        input  o_axi_bid, o_axi_bresp, o_axi_bvalid,
        output i_axi_bready,
        output i_axi_arid, i_axi_araddr, i_axi_arlen, i_axi_arburst, i_axi_arvalid,
        input  o_axi_arready,
        input  o_axi_rid, o_axi_rdata, o_axi_rresp, o_axi_rlast, o_axi_rvalid,
        output i_axi_rready,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
        output i_wb_stall, i_wb_ack, i_wb_err, i_wb_data
    );
endinterface

// File: rtl/axi2wbm.sv
// axi2wbm: AXI4 slave to pipelined-Wishbone master bridge.
// Each AXI burst is issued as single-beat Wishbone transactions, with one
// request outstanding at a time. Reads and writes share the Wishbone port
// under round-robin arbitration.
// Ports:
//   i_clk      single clock
//   i_reset_n  asynchronous, active-low reset
//   bus        axi2wbm_if.slave (AW/W/B/AR/R channels + Wishbone master)
//
// state | meaning
// IDLE  | waiting for AW or AR; round-robin when both are valid
// WDATA | wready high, waiting for the next write beat
// WBUS  | Wishbone write in flight (stb until accepted, then wait ack/err)
// BRESP | bvalid high with the accumulated error status
// RBUS  | Wishbone read in flight
// RDATA | rvalid high with the captured read beat
module axi2wbm #(
    parameter int C_AXI_ID_WIDTH   = 1,
    parameter int C_AXI_ADDR_WIDTH = 28,
    parameter int C_AXI_DATA_WIDTH = 32
) (
    input logic      i_clk,
    input logic      i_reset_n,
    axi2wbm_if.slave bus
);
    localparam int AW = C_AXI_ADDR_WIDTH - 2;
    localparam int SW = C_AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, WDATA, WBUS, BRESP, RBUS, RDATA} state_t;

    state_t                      state_q, state_d;
    logic                        running_q, running_d;
    logic                        last_was_read_q, last_was_read_d;
    logic                        err_q, err_d;
    logic [C_AXI_ID_WIDTH-1:0]   id_q, id_d;
    logic [7:0]                  len_q, len_d;
    logic [7:0]                  beat_q, beat_d;
    logic [1:0]                  burst_q, burst_d;
    logic                        cyc_q, cyc_d;
    logic                        stb_q, stb_d;
    logic                        we_q, we_d;
    logic [AW-1:0]               addr_q, addr_d;
    logic [C_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [SW-1:0]               sel_q, sel_d;
    logic [C_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]                  rresp_q, rresp_d;
    logic                        rlast_q, rlast_d;
    logic                        wready_q, wready_d;
    logic                        bvalid_q, bvalid_d;
    logic                        rvalid_q, rvalid_d;

    logic awready_c, arready_c;
    logic aw_hs, ar_hs, w_hs, b_hs, r_hs, wb_done;

    // wlast and the byte offset bits play no part in the translation.
    logic unused_ok;
    assign unused_ok = ^{bus.i_axi_wlast, bus.i_axi_awaddr[1:0], bus.i_axi_araddr[1:0]};

    // running_q keeps both address readies low while reset is asserted.
    // When both AW and AR are valid, last_was_read_q selects the winner.
    assign awready_c = running_q && (state_q == IDLE) && (!bus.i_axi_arvalid || last_was_read_q);
    assign arready_c = running_q && (state_q == IDLE) && (!bus.i_axi_awvalid || !last_was_read_q);

    assign aw_hs   = awready_c && bus.i_axi_awvalid;
    assign ar_hs   = arready_c && bus.i_axi_arvalid;
    assign w_hs    = wready_q && bus.i_axi_wvalid;
    assign b_hs    = bvalid_q && bus.i_axi_bready;
    assign r_hs    = rvalid_q && bus.i_axi_rready;
    // An ack or err is accepted even while stb is still high.
    assign wb_done = ((state_q == WBUS) || (state_q == RBUS)) && (bus.i_wb_ack || bus.i_wb_err);

    always_comb begin
        state_d         = state_q;
        running_d       = 1'b1;
        last_was_read_d = last_was_read_q;
        err_d           = err_q;
        id_d            = id_q;
        len_d           = len_q;
        beat_d          = beat_q;
        burst_d         = burst_q;
        cyc_d           = cyc_q;
        stb_d           = stb_q;
        we_d            = we_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        sel_d           = sel_q;
        rdata_d         = rdata_q;
        rresp_d         = rresp_q;
        rlast_d         = rlast_q;

        case (state_q)
            IDLE: begin
                if (aw_hs) begin
                    id_d            = bus.i_axi_awid;
                    addr_d          = bus.i_axi_awaddr[C_AXI_ADDR_WIDTH-1:2];
                    len_d           = bus.i_axi_awlen;
                    burst_d         = bus.i_axi_awburst;
                    beat_d          = 8'd0;
                    err_d           = 1'b0;
                    we_d            = 1'b1;
                    last_was_read_d = 1'b0;
                    state_d         = WDATA;
                end else if (ar_hs) begin
                    id_d            = bus.i_axi_arid;
                    addr_d          = bus.i_axi_araddr[C_AXI_ADDR_WIDTH-1:2];
                    len_d           = bus.i_axi_arlen;
                    burst_d         = bus.i_axi_arburst;
                    beat_d          = 8'd0;
                    we_d            = 1'b0;
                    cyc_d           = 1'b1;
                    stb_d           = 1'b1;
                    last_was_read_d = 1'b1;
                    state_d         = RBUS;
                end
            end
            WDATA: begin
                if (w_hs) begin
                    wdata_d = bus.i_axi_wdata;
                    sel_d   = bus.i_axi_wstrb;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    state_d = WBUS;
                end
            end
            WBUS, RBUS: begin
                if (stb_q && !bus.i_wb_stall) begin
                    stb_d = 1'b0;
                end
                if (wb_done) begin
                    stb_d = 1'b0;
                    cyc_d = 1'b0;
                    // Advance to the next beat now; FIXED bursts keep the address.
                    if (beat_q != len_q) begin
                        beat_d = beat_q + 8'd1;
                        if (burst_q != 2'b00) begin
                            addr_d = addr_q + AW'(1);
                        end
                    end
                    if (state_q == WBUS) begin
                        if (bus.i_wb_err) begin
                            err_d = 1'b1;
                        end
                        state_d = (beat_q == len_q) ? BRESP : WDATA;
                    end else begin
                        rdata_d = bus.i_wb_data;
                        rresp_d = bus.i_wb_err ? 2'b10 : 2'b00;
                        rlast_d = (beat_q == len_q);
                        state_d = RDATA;
                    end
                end
            end
            BRESP: begin
                if (b_hs) begin
                    state_d = IDLE;
                end
            end
            RDATA: begin
                if (r_hs) begin
                    if (rlast_q) begin
                        rlast_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        state_d = RBUS;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        wready_d = (state_d == WDATA);
        bvalid_d = (state_d == BRESP);
        rvalid_d = (state_d == RDATA);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q         <= IDLE;
            running_q       <= 1'b0;
            last_was_read_q <= 1'b1;
            err_q           <= 1'b0;
            id_q            <= '0;
            len_q           <= '0;
            beat_q          <= '0;
            burst_q         <= '0;
            cyc_q           <= 1'b0;
            stb_q           <= 1'b0;
            we_q            <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            sel_q           <= '0;
            rdata_q         <= '0;
            rresp_q         <= '0;
            rlast_q         <= 1'b0;
            wready_q        <= 1'b0;
            bvalid_q        <= 1'b0;
            rvalid_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            running_q       <= running_d;
            last_was_read_q <= last_was_read_d;
            err_q           <= err_d;
            id_q            <= id_d;
            len_q           <= len_d;
            beat_q          <= beat_d;
            burst_q         <= burst_d;
            cyc_q           <= cyc_d;
            stb_q           <= stb_d;
            we_q            <= we_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            sel_q           <= sel_d;
            rdata_q         <= rdata_d;
            rresp_q         <= rresp_d;
            rlast_q         <= rlast_d;
            wready_q        <= wready_d;
            bvalid_q        <= bvalid_d;
            rvalid_q        <= rvalid_d;
        end
    end

    assign bus.o_axi_awready = awready_c;
    assign bus.o_axi_arready = arready_c;
    assign bus.o_axi_wready  = wready_q;
    assign bus.o_axi_bvalid  = bvalid_q;
    assign bus.o_axi_bid     = id_q;
    assign bus.o_axi_bresp   = (bvalid_q && err_q) ? 2'b10 : 2'b00;
    assign bus.o_axi_rvalid  = rvalid_q;
    assign bus.o_axi_rid     = id_q;
    assign bus.o_axi_rdata   = rdata_q;
    assign bus.o_axi_rresp   = rresp_q;
    assign bus.o_axi_rlast   = rlast_q;
    assign bus.o_wb_cyc      = cyc_q;
    assign bus.o_wb_stb      = stb_q;
    assign bus.o_wb_we       = we_q;
    assign bus.o_wb_addr     = addr_q;
    assign bus.o_wb_data     = wdata_q;
    assign bus.o_wb_sel      = sel_q;
endmodule

// File: tb/tb_axi2wbm.sv
// tb_axi2wbm: scoreboard bench for the axi2wbm bridge. A Wishbone slave
// model with programmable stall and error injection logs every accepted
// request; expected requests and AXI responses are queued as stimulus is
// issued and popped when the bridge produces them.
module tb_axi2wbm;
    localparam int ID_W   = 1;
    localparam int ADDR_W = 28;
    localparam int DATA_W = 32;
    localparam int AW     = ADDR_W - 2;
    localparam int BUDGET = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi2wbm_if #(.C_AXI_ID_WIDTH(ID_W), .C_AXI_ADDR_WIDTH(ADDR_W), .C_AXI_DATA_WIDTH(DATA_W)) bus ();

    axi2wbm #(.C_AXI_ID_WIDTH(ID_W), .C_AXI_ADDR_WIDTH(ADDR_W), .C_AXI_DATA_WIDTH(DATA_W)) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .bus      (bus)
    );

    typedef struct {
        bit          we;
        logic [AW-1:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        int          hold;
        bit          stable;
    } wb_t;
    typedef struct {
        logic [31:0]     data;
        logic [1:0]      resp;
        logic            last;
        logic [ID_W-1:0] id;
    } r_t;
    typedef struct {
        logic [1:0]      resp;
        logic [ID_W-1:0] id;
    } b_t;

    wb_t wb_obs[$];
    wb_t wb_wexp[$];
    wb_t wb_rexp[$];
    r_t  r_exp[$];
    b_t  b_exp[$];
    int  hs_order[$];

    int checks = 0;
    int errors = 0;

    int  stall_cfg = 0;
    int  err_idx   = -1;
    int  req_cnt   = 0;
    int  hold_cnt  = 0;
    bit  pend      = 0;
    bit  pend_err  = 0;
    wb_t cur;

    function automatic logic [31:0] rd_data(input logic [AW-1:0] a);
        return 32'hA500_0000 | {6'b0, a};
    endfunction

    // Wishbone slave model: decides stall/ack/err for the coming rising edge.
    always @(negedge clk) begin
        bus.i_wb_ack   = 1'b0;
        bus.i_wb_err   = 1'b0;
        bus.i_wb_stall = 1'b0;
        if (!rst_n) begin
            pend           = 0;
            hold_cnt       = 0;
            bus.i_wb_data  = '0;
        end else begin
            if (pend) begin
                if (pend_err) bus.i_wb_err = 1'b1;
                else          bus.i_wb_ack = 1'b1;
                bus.i_wb_data = rd_data(cur.addr);
                pend = 0;
            end
            if (bus.o_wb_cyc && bus.o_wb_stb) begin
                if (hold_cnt == 0) begin
                    cur.we = bus.o_wb_we; cur.addr = bus.o_wb_addr;
                    cur.data = bus.o_wb_data; cur.sel = bus.o_wb_sel; cur.stable = 1;
                end else if (cur.we != bus.o_wb_we || cur.addr != bus.o_wb_addr ||
                             cur.data != bus.o_wb_data || cur.sel != bus.o_wb_sel) begin
                    cur.stable = 0;
                end
                hold_cnt++;
                if (hold_cnt <= stall_cfg) begin
                    bus.i_wb_stall = 1'b1;
                end else begin
                    cur.hold = hold_cnt;
                    wb_obs.push_back(cur);
                    pend     = 1;
                    pend_err = (req_cnt == err_idx);
                    req_cnt++;
                    hold_cnt = 0;
                end
            end
        end
    end

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        bus.i_axi_awvalid = 0; bus.i_axi_wvalid = 0; bus.i_axi_arvalid = 0;
        wb_obs.delete(); wb_wexp.delete(); wb_rexp.delete();
        r_exp.delete(); b_exp.delete(); hs_order.delete();
        req_cnt = 0; err_idx = -1; stall_cfg = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic axi_write(input logic [ID_W-1:0] id, input logic [27:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [31:0] data0, input logic [3:0] strb,
                             input int err_beat);
        logic [AW-1:0] wa;
        wb_t e, o;
        b_t  be, bo;
        int  n;
        wa = addr[27:2];
        for (int b = 0; b <= int'(len); b++) begin
            e.we = 1; e.addr = wa; e.data = data0 + 32'(b) * 32'h0101_0101;
            e.sel = strb; e.hold = stall_cfg + 1; e.stable = 1;
            wb_wexp.push_back(e);
            if (burst != 2'b00) wa = wa + AW'(1);
        end
        be.resp = (err_beat >= 0 && err_beat <= int'(len)) ? 2'b10 : 2'b00;
        be.id   = id;
        b_exp.push_back(be);
        if (err_beat >= 0) err_idx = req_cnt + err_beat;

        @(negedge clk);
        bus.i_axi_awid = id; bus.i_axi_awaddr = addr; bus.i_axi_awlen = len;
        bus.i_axi_awburst = burst; bus.i_axi_awvalid = 1;
        n = 0;
        #1;
        while (!bus.o_axi_awready) begin
            @(negedge clk); #1;
            if (++n > BUDGET) begin
                $display("FAIL aw_timeout got awready=0 want 1"); errors++; checks++;
                bus.i_axi_awvalid = 0; return;
            end
        end
        hs_order.push_back(0);
        @(negedge clk);
        bus.i_axi_awvalid = 0;

        for (int b = 0; b <= int'(len); b++) begin
            bus.i_axi_wdata = data0 + 32'(b) * 32'h0101_0101;
            bus.i_axi_wstrb = strb; bus.i_axi_wlast = (b == int'(len)); bus.i_axi_wvalid = 1;
            n = 0;
            #1;
            while (!bus.o_axi_wready) begin
                @(negedge clk); #1;
                if (++n > BUDGET) begin
                    $display("FAIL w_timeout got wready=0 want 1"); errors++; checks++;
                    bus.i_axi_wvalid = 0; return;
                end
            end
            @(negedge clk);
            bus.i_axi_wvalid = 0;
        end

        n = 0;
        #1;
        while (!bus.o_axi_bvalid) begin
            @(negedge clk); #1;
            if (++n > BUDGET) begin
                $display("FAIL b_timeout got bvalid=0 want 1"); errors++; checks++; return;
            end
        end
        bo = b_exp.pop_front();
        checks++;
        if (bus.o_axi_bresp !== bo.resp || bus.o_axi_bid !== bo.id) begin
            $display("FAIL bresp got resp=%b id=%h want resp=%b id=%h",
                     bus.o_axi_bresp, bus.o_axi_bid, bo.resp, bo.id);
            errors++;
        end
        @(negedge clk);

        for (int b = 0; b <= int'(len); b++) begin
            e = wb_wexp.pop_front();
            checks++;
            if (wb_obs.size() == 0) begin
                $display("FAIL wb_write got no request want addr=%h", e.addr); errors++;
            end else begin
                o = wb_obs.pop_front();
                if (o.we !== e.we || o.addr !== e.addr || o.data !== e.data || o.sel !== e.sel ||
                    o.hold != e.hold || !o.stable) begin
                    $display("FAIL wb_write got we=%b addr=%h data=%h sel=%h hold=%0d stable=%0d want we=%b addr=%h data=%h sel=%h hold=%0d stable=1",
                             o.we, o.addr, o.data, o.sel, o.hold, o.stable, e.we, e.addr, e.data, e.sel, e.hold);
                    errors++;
                end
            end
        end
    endtask

    task automatic axi_read(input logic [ID_W-1:0] id, input logic [27:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int err_beat);
        logic [AW-1:0] ra;
        wb_t e, o;
        r_t  re, ro;
        int  n;
        ra = addr[27:2];
        for (int b = 0; b <= int'(len); b++) begin
            e.we = 0; e.addr = ra; e.data = '0; e.sel = '0; e.hold = stall_cfg + 1; e.stable = 1;
            wb_rexp.push_back(e);
            re.data = rd_data(ra); re.resp = (b == err_beat) ? 2'b10 : 2'b00;
            re.last = (b == int'(len)); re.id = id;
            r_exp.push_back(re);
            if (burst != 2'b00) ra = ra + AW'(1);
        end
        if (err_beat >= 0) err_idx = req_cnt + err_beat;

        @(negedge clk);
        bus.i_axi_arid = id; bus.i_axi_araddr = addr; bus.i_axi_arlen = len;
        bus.i_axi_arburst = burst; bus.i_axi_arvalid = 1;
        n = 0;
        #1;
        while (!bus.o_axi_arready) begin
            @(negedge clk); #1;
            if (++n > BUDGET) begin
                $display("FAIL ar_timeout got arready=0 want 1"); errors++; checks++;
                bus.i_axi_arvalid = 0; return;
            end
        end
        hs_order.push_back(1);
        @(negedge clk);
        bus.i_axi_arvalid = 0;

        for (int b = 0; b <= int'(len); b++) begin
            n = 0;
            #1;
            while (!bus.o_axi_rvalid) begin
                @(negedge clk); #1;
                if (++n > BUDGET) begin
                    $display("FAIL r_timeout got rvalid=0 want 1 beat=%0d", b); errors++; checks++; return;
                end
            end
            ro = r_exp.pop_front();
            checks++;
            if (bus.o_axi_rdata !== ro.data || bus.o_axi_rresp !== ro.resp ||
                bus.o_axi_rlast !== ro.last || bus.o_axi_rid !== ro.id) begin
                $display("FAIL rbeat%0d got data=%h resp=%b last=%b id=%h want data=%h resp=%b last=%b id=%h",
                         b, bus.o_axi_rdata, bus.o_axi_rresp, bus.o_axi_rlast, bus.o_axi_rid,
                         ro.data, ro.resp, ro.last, ro.id);
                errors++;
            end
            @(negedge clk);
        end

        for (int b = 0; b <= int'(len); b++) begin
            e = wb_rexp.pop_front();
            checks++;
            if (wb_obs.size() == 0) begin
                $display("FAIL wb_read got no request want addr=%h", e.addr); errors++;
            end else begin
                o = wb_obs.pop_front();
                if (o.we !== e.we || o.addr !== e.addr || o.hold != e.hold || !o.stable) begin
                    $display("FAIL wb_read got we=%b addr=%h hold=%0d stable=%0d want we=0 addr=%h hold=%0d stable=1",
                             o.we, o.addr, o.hold, o.stable, e.addr, e.hold);
                    errors++;
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_we} !== 3'b000) begin
            $display("FAIL reset_wb got cyc/stb/we=%b want 000", {bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_we});
            errors++;
        end
        checks++;
        if ({bus.o_axi_awready, bus.o_axi_arready, bus.o_axi_wready, bus.o_axi_bvalid,
             bus.o_axi_rvalid, bus.o_axi_rlast, bus.o_axi_bresp, bus.o_axi_rresp} !== 10'b0) begin
            $display("FAIL reset_axi got aw/ar/w/b/r/last/bresp/rresp=%b want 0",
                     {bus.o_axi_awready, bus.o_axi_arready, bus.o_axi_wready, bus.o_axi_bvalid,
                      bus.o_axi_rvalid, bus.o_axi_rlast, bus.o_axi_bresp, bus.o_axi_rresp});
            errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_write();
        axi_write(1'b1, 28'h000_0100, 8'd0, 2'b01, 32'hDEAD_BEEF, 4'hF, -1);
    endtask

    task automatic test_reads();
        axi_read(1'b0, 28'h000_0200, 8'd3, 2'b01, -1);
        axi_read(1'b1, 28'h000_0300, 8'd1, 2'b00, -1);
        axi_read(1'b0, 28'hFFF_FFFC, 8'd1, 2'b01, -1);
    endtask

    task automatic test_stall();
        stall_cfg = 3;
        axi_write(1'b0, 28'h000_0040, 8'd1, 2'b01, 32'h1234_5678, 4'h5, -1);
        stall_cfg = 0;
        checks++;
        if (wb_obs.size() != 0) begin
            $display("FAIL extra_wb got %0d leftover requests want 0", wb_obs.size()); errors++;
        end
    endtask

    task automatic test_errors();
        axi_read(1'b1, 28'h000_0500, 8'd3, 2'b01, 1);
        axi_write(1'b0, 28'h000_0600, 8'd1, 2'b01, 32'hCAFE_0000, 4'hF, 0);
        axi_write(1'b1, 28'h000_0700, 8'd0, 2'b01, 32'h0BAD_F00D, 4'h3, -1);
    endtask

    task automatic test_arbitration();
        reset_dut();
        fork
            axi_write(1'b1, 28'h000_0400, 8'd0, 2'b01, 32'h1111_2222, 4'hF, -1);
            axi_read(1'b0, 28'h000_0800, 8'd1, 2'b01, -1);
        join
        checks++;
        if (hs_order.size() != 2 || hs_order[0] != 0 || hs_order[1] != 1) begin
            $display("FAIL arb_first got order=%p want '{0,1}", hs_order); errors++;
        end
        axi_write(1'b0, 28'h000_0900, 8'd0, 2'b01, 32'h3333_4444, 4'hF, -1);
        hs_order.delete();
        fork
            axi_write(1'b1, 28'h000_0A00, 8'd0, 2'b01, 32'h5555_6666, 4'hF, -1);
            axi_read(1'b1, 28'h000_0B00, 8'd0, 2'b01, -1);
        join
        checks++;
        if (hs_order.size() != 2 || hs_order[0] != 1 || hs_order[1] != 0) begin
            $display("FAIL arb_alternate got order=%p want '{1,0}", hs_order); errors++;
        end
    endtask

    task automatic test_reset_mid();
        int n;
        reset_dut();
        stall_cfg = 50;
        @(negedge clk);
        bus.i_axi_arid = 1'b0; bus.i_axi_araddr = 28'h000_0C00; bus.i_axi_arlen = 8'd2;
        bus.i_axi_arburst = 2'b01; bus.i_axi_arvalid = 1;
        n = 0;
        #1;
        while (!bus.o_axi_arready && n <= BUDGET) begin @(negedge clk); #1; n++; end
        @(negedge clk);
        bus.i_axi_arvalid = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.o_wb_stb !== 1'b1) begin
            $display("FAIL mid_stb got stb=%b want 1", bus.o_wb_stb); errors++;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.o_wb_cyc, bus.o_wb_stb, bus.o_axi_rvalid} !== 3'b000) begin
            $display("FAIL mid_reset got cyc/stb/rvalid=%b want 000",
                     {bus.o_wb_cyc, bus.o_wb_stb, bus.o_axi_rvalid});
            errors++;
        end
        stall_cfg = 0;
        wb_obs.delete(); req_cnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        axi_read(1'b1, 28'h000_0D00, 8'd1, 2'b01, -1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_axi_awid = '0; bus.i_axi_awaddr = '0; bus.i_axi_awlen = '0; bus.i_axi_awburst = '0;
        bus.i_axi_awvalid = 0;
        bus.i_axi_wdata = '0; bus.i_axi_wstrb = '0; bus.i_axi_wlast = 0; bus.i_axi_wvalid = 0;
        bus.i_axi_bready = 1;
        bus.i_axi_arid = '0; bus.i_axi_araddr = '0; bus.i_axi_arlen = '0; bus.i_axi_arburst = '0;
        bus.i_axi_arvalid = 0;
        bus.i_axi_rready = 1;

        test_reset();
        test_single_write();
        test_reads();
        test_stall();
        test_errors();
        test_arbitration();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
